// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit : iterative radix-2 restoring divider (DIV / DIVU).
//
// Accepts a divide from the execute stage, stalls the pipeline while it runs
// one quotient bit per clock, then pulses div_ready for one cycle with
// div_result = {HI = remainder, LO = quotient}. Signed divides are done on
// magnitudes and sign-corrected at the end (quotient sign = sign(a)^sign(b),
// remainder takes the sign of the dividend).
//
// Ports
//   clk         in   1        rising-edge clock
//   rst         in   1        asynchronous active-high reset
//   div_start   in   1        execute stage holds a divide, operands valid
//   div_signed  in   1        1 = DIV, 0 = DIVU (sampled with div_start)
//   div_annul   in   1        flush of the divide; aborts, returns to IDLE
//   opa         in   WIDTH    dividend
//   opb         in   WIDTH    divisor
//   div_stall   out  1        combinational stall request to hazard unit
//   div_ready   out  1        one-cycle result-valid pulse
//   div_result  out  2*WIDTH  {remainder, quotient}, held until next result
//
// Optional feature macro: DIV_ZERO_FAST_EN
//   When defined, a zero divisor skips the iterations (IDLE -> DONE) and
//   produces the same HI/LO values as the full restoring run.
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic               div_annul,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               div_stall,
  output logic               div_ready,
  output logic [2*WIDTH-1:0] div_result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement negate when neg is set; used both for taking operand
  // magnitudes and for the final sign correction.
  function automatic logic [WIDTH-1:0] f_sign_fix(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? (-v) : v;
  endfunction

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic               r_qsign;
  logic               r_rsign;
  logic               r_ready;
  logic [2*WIDTH-1:0] r_result;

  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_accept;
  logic               w_fast;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_trial;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;

  // Operand magnitudes; a negative MIN value wraps to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign w_neg_a  = div_signed & opa[WIDTH-1];
  assign w_neg_b  = div_signed & opb[WIDTH-1];
  assign w_abs_a  = f_sign_fix(opa, w_neg_a);
  assign w_abs_b  = f_sign_fix(opb, w_neg_b);

  assign w_accept = (r_state == S_IDLE) & div_start & ~div_annul;

`ifdef DIV_ZERO_FAST_EN
  assign w_fast = (opb == '0);
`else
  assign w_fast = 1'b0;
`endif

  // One restoring step. The shifted partial remainder needs WIDTH+1 bits
  // for the compare; when no borrow occurs the difference is below the
  // divisor, so its low WIDTH bits are exact.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_borrow = (w_shift < {1'b0, r_div});
  assign w_trial  = w_shift[WIDTH-1:0] - r_div;
  assign w_rem_nx = w_borrow ? w_shift[WIDTH-1:0] : w_trial;
  assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_borrow};

  // Stall drops in DONE so the pipeline advances as the result lands, and
  // drops immediately when the divide is flushed.
  assign div_stall  = w_accept | ((r_state == S_BUSY) & ~div_annul);
  assign div_ready  = r_ready;
  assign div_result = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else if (div_annul) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (div_start) begin
            r_div   <= w_abs_b;
            r_qsign <= w_neg_a ^ w_neg_b;
            r_rsign <= w_neg_a;
            r_cnt   <= '0;
            if (w_fast) begin
              // Load what the full run would leave for a zero divisor.
              r_rem   <= w_abs_a;
              r_quo   <= '1;
              r_state <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_abs_a;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          r_ready  <= 1'b1;
          r_result <= {f_sign_fix(r_rem, r_rsign), f_sign_fix(r_quo, r_qsign)};
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit : self-checking bench for div_unit (WIDTH = 32).
// Table of divide vectors applied in a loop with a scoreboard queue of
// expected {HI,LO}; hand-written sequences cover start-in-DONE, annul and
// asynchronous reset during an operation.
// ---------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           div_start;
  logic           div_signed;
  logic           div_annul;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic           div_stall;
  logic           div_ready;
  logic [2*W-1:0] div_result;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[14];

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_start (div_start),
    .div_signed(div_signed),
    .div_annul (div_annul),
    .opa       (opa),
    .opb       (opb),
    .div_stall (div_stall),
    .div_ready (div_ready),
    .div_result(div_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == '0) ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  function automatic int exp_stall(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == '0) ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  // Called at posedge+1. Issues one divide, measures edges to ready and
  // stall cycles, and checks the popped expectation against the result.
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input string nm);
    int n;
    int st;
    logic got;
    logic [2*W-1:0] e;
    div_signed = sgn;
    opa        = a;
    opb        = b;
    div_start  = 1'b1;
    #1;
    st = int'(div_stall);
    exp_q.push_back({hi, lo});
    @(posedge clk);
    #1;
    div_start = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      if (div_ready) got = 1'b1;
      else begin
        st = st + int'(div_stall);
        @(posedge clk);
        #1;
        n++;
      end
    end
    if (!got) begin
      chk({nm, " timeout"}, 64'(n), 64'(exp_lat(b)));
      void'(exp_q.pop_front());
    end else begin
      chk({nm, " latency"}, 64'(n), 64'(exp_lat(b)));
      chk({nm, " stall"}, 64'(st), 64'(exp_stall(b)));
      if (exp_q.size() == 0) chk({nm, " unexpected ready"}, 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk({nm, " result"}, div_result, e);
      end
      @(posedge clk);
      #1;
      chk({nm, " pulse"}, 64'(div_ready), 64'd0);
      chk({nm, " held"}, div_result, {hi, lo});
    end
  endtask

  task automatic watch_no_ready(input string nm, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (div_ready) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] prev;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF};
    vecs[4]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   32'd1};
    vecs[5]  = '{1'b1, 32'd20,         32'hFFFFFFFA,   32'd2,          32'hFFFFFFFD};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          32'd1};
    vecs[8]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD};
    vecs[9]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF,   32'd3};
    vecs[10] = '{1'b0, 32'd3,          32'd10,         32'd3,          32'd0};
    vecs[11] = '{1'b0, 32'h80000000,   32'd2,          32'd0,          32'h40000000};
    vecs[12] = '{1'b1, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF};
    vecs[13] = '{1'b0, 32'hDEADBEEF,   32'h10,         32'hF,          32'h0DEADBEE};

    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    opa        = '0;
    opb        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 64'(div_ready), 64'd0);
    chk("reset result", div_result, 64'd0);
    chk("reset stall", 64'(div_stall), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Start seen in DONE is ignored; stall is low in DONE.
    div_signed = 1'b0;
    opa        = 32'd100;
    opb        = 32'd7;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (W) begin
      @(posedge clk);
      #1;
    end
    div_start = 1'b1;
    #1;
    chk("done stall", 64'(div_stall), 64'd0);
    @(posedge clk);
    #1;
    div_start = 1'b0;
    chk("done ready", 64'(div_ready), 64'd1);
    chk("done result", div_result, {32'd2, 32'd14});
    @(posedge clk);
    #1;
    watch_no_ready("done start ignored", 40);

    // Annul part way through: no ready, result unchanged, stall drops at once.
    prev       = div_result;
    div_signed = 1'b0;
    opa        = 32'd9;
    opb        = 32'd3;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("busy stall", 64'(div_stall), 64'd1);
    div_annul = 1'b1;
    #1;
    chk("annul stall", 64'(div_stall), 64'd0);
    @(posedge clk);
    #1;
    div_annul = 1'b0;
    watch_no_ready("annul no ready", 40);
    chk("annul result kept", div_result, prev);
    run_op(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, "after annul");

    // Asynchronous reset mid-operation.
    div_signed = 1'b0;
    opa        = 32'd50;
    opb        = 32'd3;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst ready", 64'(div_ready), 64'd0);
    chk("async rst result", div_result, 64'd0);
    chk("async rst stall", 64'(div_stall), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    watch_no_ready("rst discards op", 40);
    run_op(1'b1, 32'd20, 32'hFFFFFFFA, 32'd2, 32'hFFFFFFFD, "after rst");

    chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
